bf8b_mem_responder: RTL and testbench

// - Memory-side responder for the bf8b core's flat memory port: answers word-addressed reads and

---
 rtl/bf8b_mem_responder_pkg.sv | 24 ++
 rtl/bf8b_mem_responder_sync_fifo.sv | 65 ++++++
 rtl/bf8b_mem_responder.sv | 140 ++++++++++++++
 tb/tb_bf8b_mem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf8b_mem_responder_pkg.sv
// ============================================================================
// Module  : bf8b_mem_pkg
// Brief   : MMIO map and STATUS bit layout for the bf8b memory responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bf8b_mem_pkg;

    localparam int MMIO_WORDS = 8;

    localparam logic [2:0] MMIO_CONSOLE  = 3'd0;
    localparam logic [2:0] MMIO_STATUS   = 3'd1;
    localparam logic [2:0] MMIO_CYCLE_LO = 3'd2;
    localparam logic [2:0] MMIO_CYCLE_HI = 3'd3;
    localparam logic [2:0] MMIO_HALT     = 3'd4;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_OVERFLOW = 2;

endpackage

`default_nettype wire

// File: rtl/bf8b_mem_responder_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO, power-of-two depth, registered count, no bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bf8b_mem_responder.sv
// ============================================================================
// Module  : bf8b_mem_responder
// Brief   : Word RAM plus MMIO window (console FIFO, status, cycle counter,
//           halt) answering the bf8b core's flat memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bf8b_mem_responder
    import bf8b_mem_pkg::*;
#(
    parameter int          M_WIDTH   = 32,
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] MMIO_BASE = 64'h3FFF_FFC0,
    parameter int          TX_DEPTH  = 16,
    parameter string       INIT_FILE = ""
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [M_WIDTH-$clog2(M_WIDTH/8)-1:0]  addr,
    input  logic [M_WIDTH-1:0]                    wdata,
    input  logic [M_WIDTH/8-1:0]                  wes,
    output logic [M_WIDTH-1:0]                    rdata,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  halt,
    output logic [7:0]                            exit_code
);

    localparam int                c_LANES  = M_WIDTH / 8;
    localparam int                c_AW     = M_WIDTH - $clog2(c_LANES);
    localparam int                c_RAM_AW = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH  = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW-1:0]   c_BASE   = MMIO_BASE[c_AW-1:0];
    localparam int                c_CNT_W  = $clog2(TX_DEPTH) + 1;

    logic [M_WIDTH-1:0]  r_ram [DEPTH];
    logic [M_WIDTH-1:0]  r_rdata;
    logic [63:0]         r_cycle;
    logic [31:0]         r_shadow;
    logic                r_halt;
    logic [7:0]          r_exit_code;
    logic                r_overflow;

    logic                w_ram_hit;
    logic                w_mmio_sel;
    logic [c_AW-1:0]     w_off;
    logic [2:0]          w_mmio_off;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic [M_WIDTH-1:0]  w_rd;
    logic                w_console_wr;
    logic                w_halt_wr;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;

    // RAM takes precedence should a parameterisation make the regions overlap.
    assign w_ram_hit  = ({1'b0, addr} < c_DEPTH);
    assign w_off      = addr - c_BASE;
    assign w_mmio_sel = !w_ram_hit && (w_off < c_AW'(MMIO_WORDS));
    assign w_mmio_off = w_off[2:0];
    assign w_ram_idx  = addr[c_RAM_AW-1:0];

    assign w_console_wr = !rst && w_mmio_sel && (w_mmio_off == MMIO_CONSOLE) && wes[0];
    assign w_halt_wr    = !rst && w_mmio_sel && (w_mmio_off == MMIO_HALT) && wes[0];
    assign w_pop        = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (!rst && w_ram_hit) begin
            for (int k = 0; k < c_LANES; k++) begin
                if (wes[k]) r_ram[w_ram_idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_ram_hit) begin
            w_rd = r_ram[w_ram_idx];
        end else if (w_mmio_sel) begin
            case (w_mmio_off)
                MMIO_STATUS: begin
                    w_rd[STAT_FULL]     = w_full;
                    w_rd[STAT_EMPTY]    = w_empty;
                    w_rd[STAT_OVERFLOW] = r_overflow;
                end
                MMIO_CYCLE_LO: w_rd[31:0] = r_cycle[31:0];
                MMIO_CYCLE_HI: w_rd[31:0] = r_shadow;
                MMIO_HALT:     w_rd[15:0] = {r_exit_code, 7'b0, r_halt};
                default:       w_rd = '0;
            endcase
        end
    end

    // Read mux samples pre-edge state, so a same-word write returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata     <= '0;
            r_cycle     <= '0;
            r_shadow    <= '0;
            r_halt      <= 1'b0;
            r_exit_code <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_rdata <= w_rd;
            r_cycle <= r_cycle + 64'd1;
            if (w_mmio_sel && (w_mmio_off == MMIO_CYCLE_LO)) r_shadow <= r_cycle[63:32];
            if (w_halt_wr && !r_halt) begin
                r_halt      <= 1'b1;
                r_exit_code <= wdata[7:0];
            end
            if (w_console_wr && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_console_wr),
        .i_din   (wdata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (tx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign tx_valid  = (w_count != '0);
    assign rdata     = r_rdata;
    assign halt      = r_halt;
    assign exit_code = r_exit_code;

endmodule

`default_nettype wire

// File: tb/tb_bf8b_mem_responder.sv
// ============================================================================
// Module  : tb_bf8b_mem_responder
// Brief   : Table-driven, directed and randomized bench with a queue/array model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bf8b_mem_responder;

    localparam int          DEPTH = 4096;
    localparam int          TXD   = 16;
    localparam logic [29:0] BASE  = 30'h3FFF_FFC0;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wes;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [7:0]  exit_code;

    always #5 clk = ~clk;

    bf8b_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .wes       (wes),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .exit_code (exit_code)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_ram   [DEPTH];
    bit          m_known [DEPTH];
    logic [7:0]  m_q[$];
    logic [31:0] m_rd;
    bit          m_rd_known = 0;
    bit          m_ovf, m_halt;
    logic [7:0]  m_exit;
    logic [63:0] m_cyc;
    logic [31:0] m_shadow;

    logic [7:0]  dut_pop[$];

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        bit          chk;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the memory responder, described by its visible rules.
    task automatic model_edge();
        bit          ram_hit, mm_hit, pop;
        int unsigned off;
        logic [31:0] nrd;
        bit          nknown;
        if (rst) begin
            m_rd = 0; m_rd_known = 1; m_q.delete();
            m_ovf = 0; m_halt = 0; m_exit = 0; m_cyc = 0; m_shadow = 0;
            return;
        end
        ram_hit = (addr < DEPTH);
        mm_hit  = (addr >= BASE) && (addr < BASE + 30'd8);
        off     = mm_hit ? int'(addr - BASE) : 0;
        nrd = 0; nknown = 1;
        if (ram_hit) begin
            nrd = m_ram[addr[11:0]]; nknown = m_known[addr[11:0]];
        end else if (mm_hit) begin
            case (off)
                1: nrd = {29'd0, m_ovf, (m_q.size() == 0), (m_q.size() == TXD)};
                2: nrd = m_cyc[31:0];
                3: nrd = m_shadow;
                4: nrd = {16'd0, m_exit, 7'd0, m_halt};
                default: nrd = 0;
            endcase
        end
        pop = (m_q.size() != 0) && tx_ready;
        if (ram_hit) begin
            for (int k = 0; k < 4; k++)
                if (wes[k]) m_ram[addr[11:0]][8*k +: 8] = wdata[8*k +: 8];
            if (wes == 4'hF) m_known[addr[11:0]] = 1;
        end
        if (mm_hit && off == 2) m_shadow = m_cyc[63:32];
        if (mm_hit && off == 4 && wes[0] && !m_halt) begin
            m_halt = 1; m_exit = wdata[7:0];
        end
        if (pop) void'(m_q.pop_front());
        if (mm_hit && off == 0 && wes[0]) begin
            if (m_q.size() < TXD) m_q.push_back(wdata[7:0]);
            else m_ovf = 1;
        end
        m_cyc = m_cyc + 1;
        m_rd = nrd; m_rd_known = nknown;
    endtask

    task automatic check_outputs();
        if (m_rd_known) check("rdata", rdata, m_rd);
        check("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
        check("halt", halt, m_halt);
        check("exit_code", exit_code, m_exit);
    endtask

    task automatic step();
        if (tx_valid && tx_ready) dut_pop.push_back(tx_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cyc(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w, input logic rdy);
        addr = a; wdata = d; wes = w; tx_ready = rdy;
        step();
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 40 && tx_valid; t++) cyc(BASE + 30'd1, 32'd0, 4'd0, 1'b1);
        check(name, tx_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; wes = '0; tx_ready = 1'b0;
        step();
        step();
        check("reset_rdata", rdata, 32'd0);
        check("reset_tx_valid", tx_valid, 1'b0);
        rst = 1'b0;

        tbl.push_back('{30'd0,           32'h0000_0000, 4'hF, 1'b0, 32'h0});
        tbl.push_back('{30'd5,           32'hAABB_CCDD, 4'hF, 1'b0, 32'h0});
        tbl.push_back('{30'd5,           32'h0000_0011, 4'h1, 1'b1, 32'hAABB_CCDD});
        tbl.push_back('{30'd5,           32'h0000_0000, 4'h0, 1'b1, 32'hAABB_CC11});
        tbl.push_back('{30'd7,           32'h0000_0001, 4'hF, 1'b0, 32'h0});
        tbl.push_back('{30'd7,           32'h0000_0002, 4'hF, 1'b1, 32'h1});
        tbl.push_back('{30'd7,           32'h0000_0000, 4'h0, 1'b1, 32'h2});
        tbl.push_back('{30'h1000,        32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0});
        tbl.push_back('{30'd0,           32'h0000_0000, 4'h0, 1'b1, 32'h0});
        tbl.push_back('{BASE + 30'd5,    32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0});
        tbl.push_back('{BASE + 30'd5,    32'h0000_0000, 4'h0, 1'b1, 32'h0});
        tbl.push_back('{BASE + 30'd1,    32'hFFFF_FFFF, 4'hF, 1'b1, 32'h2});
        tbl.push_back('{BASE,            32'h0000_0041, 4'h0, 1'b1, 32'h0});
        tbl.push_back('{30'd5,           32'h1234_5678, 4'h0, 1'b1, 32'hAABB_CC11});
        tbl.push_back('{BASE + 30'd1,    32'h0000_0000, 4'h0, 1'b1, 32'h2});
        tbl.push_back('{BASE + 30'd4,    32'h0000_0000, 4'h0, 1'b1, 32'h0});
        tbl.push_back('{30'h2000_0000,   32'h0000_0055, 4'hF, 1'b1, 32'h0});
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].a, tbl[i].d, tbl[i].w, 1'b0);
            if (tbl[i].chk) check($sformatf("tbl[%0d]", i), rdata, tbl[i].exp);
        end

        // Full FIFO with a push and a pop in the same cycle
        for (int i = 0; i < 16; i++) cyc(BASE, 32'h61 + i, 4'h1, 1'b0);
        dut_pop.delete();
        cyc(BASE, 32'h5A, 4'h1, 1'b1);
        cyc(BASE + 30'd1, 32'd0, 4'd0, 1'b0);
        check("full_no_overflow", rdata, 32'h1);
        drain("collide_drain");
        check("collide_count", dut_pop.size(), 17);
        for (int i = 0; i < 16 && i < dut_pop.size(); i++)
            check($sformatf("collide_pop[%0d]", i), dut_pop[i], 8'h61 + i);
        if (dut_pop.size() > 16) check("collide_Z", dut_pop[16], 8'h5A);
        cyc(BASE + 30'd1, 32'd0, 4'd0, 1'b0);
        check("status_empty", rdata, 32'h2);

        // Overflow: 17 writes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) cyc(BASE, 32'h41 + i, 4'h1, 1'b0);
        cyc(BASE + 30'd1, 32'd0, 4'd0, 1'b0);
        check("status_full_ovf", rdata, 32'h5);
        dut_pop.delete();
        drain("ovf_drain");
        check("ovf_count", dut_pop.size(), 16);
        for (int i = 0; i < 16 && i < dut_pop.size(); i++)
            check($sformatf("ovf_pop[%0d]", i), dut_pop[i], 8'h41 + i);
        cyc(BASE + 30'd1, 32'd0, 4'd0, 1'b0);
        check("status_empty_ovf", rdata, 32'h6);

        // Coherent LO/HI counter read across a 32-bit carry
        addr = BASE + 30'd2; wdata = '0; wes = '0; tx_ready = 1'b0;
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        m_cyc = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.r_cycle;
        step();
        check("cyc_lo", rdata, 32'hFFFF_FFFF);
        cyc(BASE + 30'd3, 32'd0, 4'd0, 1'b0);
        check("cyc_hi", rdata, 32'h0);
        cyc(BASE + 30'd2, 32'd0, 4'd0, 1'b0);
        check("cyc_lo2", rdata, 32'h1);
        cyc(BASE + 30'd3, 32'd0, 4'd0, 1'b0);
        check("cyc_hi2", rdata, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int          op;
            logic [29:0] a;
            logic [3:0]  w;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            d  = $urandom;
            w  = 4'($urandom_range(0, 15));
            case (op)
                0, 1, 2: a = 30'($urandom_range(0, 15));
                3:       a = BASE;
                4:       a = BASE + 30'd1;
                5:       a = BASE + 30'd2;
                6:       a = BASE + 30'd3;
                7:       begin a = BASE + 30'd4; w = 4'd0; end
                8:       a = BASE + 30'($urandom_range(5, 7));
                default: a = 30'(DEPTH + $urandom_range(0, 100));
            endcase
            cyc(a, d, w, ($urandom_range(0, 2) == 0));
        end

        // Halt first-write-wins, then reset with a push pending
        drain("pre_halt_drain");
        cyc(BASE + 30'd4, 32'h2A, 4'h1, 1'b0);
        cyc(BASE + 30'd4, 32'h07, 4'h1, 1'b0);
        check("halt_set", halt, 1'b1);
        check("exit_first", exit_code, 8'h2A);
        cyc(BASE + 30'd4, 32'h0, 4'h0, 1'b0);
        check("halt_read", rdata, 32'h0000_2A01);
        cyc(30'd9, 32'h1234_5678, 4'hF, 1'b0);
        cyc(BASE, 32'h78, 4'h1, 1'b0);
        rst = 1'b1;
        cyc(BASE, 32'h79, 4'h1, 1'b0);
        rst = 1'b0;
        check("rst_halt", halt, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        cyc(BASE + 30'd2, 32'd0, 4'd0, 1'b0);
        check("cyc_restart", rdata, 32'h0);
        cyc(BASE + 30'd2, 32'd0, 4'd0, 1'b0);
        check("cyc_restart1", rdata, 32'h1);
        cyc(30'd9, 32'd0, 4'd0, 1'b0);
        check("ram_kept", rdata, 32'h1234_5678);
        cyc(BASE + 30'd1, 32'd0, 4'd0, 1'b0);
        check("rst_status", rdata, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
